// File: rtl/tile_scroller.sv
// tile_scroller: falling-tile board for the piano game; shifts on synchronized beats,
// spawns LFSR-chosen tiles at the top and scores key presses against the bottom row.
module tile_scroller #(
  parameter int         ROWS      = 4,
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         SCORE_MAX = 999
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              stop,
  input  logic              clk_beat,
  input  logic              key_valid,
  input  logic [1:0]        key_col,
  output logic [ROWS-1:0]   tile_valid,
  output logic [2*ROWS-1:0] tile_col,
  output logic [9:0]        score,
  output logic              hit,
  output logic              miss,
  output logic              game_over
);
  localparam logic [9:0] SCORE_TOP = 10'(SCORE_MAX);
  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
  state_t state, state_nx;
  logic [2:0] beat_sync;
  logic beat_tick;
  logic [7:0] lfsr, lfsr_nx;
  logic [ROWS-1:0] valid_nx;
  logic [2*ROWS-1:0] col_nx;
  logic [9:0] score_nx;
  logic active, key_ok, key_bad, tick_miss, do_shift, do_hit, miss_nx;
  // two synchronizer stages plus one history stage for the rising-edge detector
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) beat_sync <= '0;
    else beat_sync <= {beat_sync[1:0], clk_beat};
  assign beat_tick = beat_sync[1] & ~beat_sync[2];
  assign active    = state == RUN && !stop && !restart;
  assign key_ok    = key_valid && tile_valid[0] && key_col == tile_col[1:0];
  assign key_bad   = key_valid && !key_ok;
  // a correct key in the tick cycle clears the bottom tile before the shift judges it
  assign tick_miss = beat_tick && tile_valid[0] && !key_ok;
  assign do_shift  = active && beat_tick && !key_bad && !tick_miss;
  assign do_hit    = active && key_ok;
  assign miss_nx   = active && (key_bad || tick_miss);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = restart ? RUN : miss_nx ? OVER : state;
  always_comb begin
    valid_nx = tile_valid;
    col_nx   = tile_col;
    lfsr_nx  = lfsr;
    score_nx = (do_hit && score != SCORE_TOP) ? score + 10'd1 : score;
    if (restart) begin
      valid_nx = '0;
      col_nx   = '0;
      lfsr_nx  = LFSR_SEED;
      score_nx = '0;
    end else if (do_shift) begin
      valid_nx = {1'b1, tile_valid[ROWS-1:1]};
      col_nx   = {lfsr[1:0], tile_col[2*ROWS-1:2]};
      lfsr_nx  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end else if (do_hit) begin
      valid_nx[0] = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tile_valid <= '0;
      tile_col   <= '0;
      score      <= '0;
      lfsr       <= LFSR_SEED;
      hit        <= 1'b0;
      miss       <= 1'b0;
    end else begin
      tile_valid <= valid_nx;
      tile_col   <= col_nx;
      score      <= score_nx;
      lfsr       <= lfsr_nx;
      hit        <= do_hit;
      miss       <= miss_nx;
    end
  assign game_over = state == OVER;
endmodule

// File: tb/tb_tile_scroller.sv
// tb_tile_scroller: directed and random stimulus for tile_scroller against a board model.
module tb_tile_scroller;
  localparam int ROWS = 4;
  localparam int SMAX = 20;
  localparam logic [7:0] SEED = 8'hA5;
  logic clk = 0, rst_n = 1, restart = 0, stop = 0, clk_beat = 0, key_valid = 0;
  logic [1:0] key_col = 0;
  logic [ROWS-1:0] tile_valid;
  logic [2*ROWS-1:0] tile_col;
  logic [9:0] score;
  logic hit, miss, game_over;
  int checks = 0, errors = 0;
  tile_scroller #(.ROWS(ROWS), .LFSR_SEED(SEED), .SCORE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .stop(stop), .clk_beat(clk_beat),
    .key_valid(key_valid), .key_col(key_col), .tile_valid(tile_valid), .tile_col(tile_col),
    .score(score), .hit(hit), .miss(miss), .game_over(game_over)
  );
  always #5 clk = ~clk;
  // model: game state 0 idle, 1 running, 2 over; rows indexed 0 = bottom
  int m_state = 0, m_score = 0;
  bit m_v[ROWS];
  bit [1:0] m_c[ROWS];
  bit m_hit = 0, m_miss = 0;
  bit [7:0] m_lfsr = SEED;
  bit [2:0] m_hist = 0;
  function automatic bit [7:0] lfsr_step(input bit [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction
  always @(posedge clk or negedge rst_n) begin
    bit tick, kok;
    if (!rst_n) begin
      m_state = 0; m_score = 0; m_hit = 0; m_miss = 0; m_lfsr = SEED; m_hist = 0;
      for (int r = 0; r < ROWS; r++) begin m_v[r] = 0; m_c[r] = 0; end
    end else begin
      tick = m_hist[1] && !m_hist[2];
      m_hist = {m_hist[1:0], clk_beat};
      m_hit = 0; m_miss = 0;
      kok = key_valid && m_v[0] && key_col == m_c[0];
      if (restart) begin
        m_state = 1; m_score = 0; m_lfsr = SEED;
        for (int r = 0; r < ROWS; r++) begin m_v[r] = 0; m_c[r] = 0; end
      end else if (m_state == 1 && !stop) begin
        if ((key_valid && !kok) || (tick && m_v[0] && !kok)) begin
          m_miss = 1; m_state = 2;
        end else begin
          if (tick) begin
            for (int r = 0; r < ROWS - 1; r++) begin m_v[r] = m_v[r+1]; m_c[r] = m_c[r+1]; end
            m_v[ROWS-1] = 1; m_c[ROWS-1] = m_lfsr[1:0];
            m_lfsr = lfsr_step(m_lfsr);
          end
          if (kok) begin
            m_hit = 1;
            if (!tick) m_v[0] = 0;
            if (m_score < SMAX) m_score++;
          end
        end
      end
    end
  end
  always @(negedge clk) begin
    logic [ROWS-1:0] ev;
    logic [2*ROWS-1:0] ec;
    ev = '0; ec = '0;
    for (int r = 0; r < ROWS; r++) begin ev[r] = m_v[r]; ec[2*r+:2] = m_c[r]; end
    checks++;
    if ({tile_valid, tile_col, score, hit, miss, game_over} !==
        {ev, ec, 10'(m_score), m_hit, m_miss, m_state == 2}) begin
      errors++;
      $display("FAIL model t=%0t got v=%b c=%h s=%0d h=%b m=%b go=%b want v=%b c=%h s=%0d h=%b m=%b go=%b",
               $time, tile_valid, tile_col, score, hit, miss, game_over,
               ev, ec, m_score, m_hit, m_miss, m_state == 2);
    end
  end
  task automatic expect_lit(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask
  // rise lands at the next edge; the tick acts on the third edge, where k/rs are applied
  task automatic beat(input bit k, input bit rs, input logic [1:0] col);
    clk_beat = 1;
    repeat (2) @(negedge clk);
    key_valid = k; key_col = col; restart = rs;
    @(negedge clk);
    key_valid = 0; restart = 0; clk_beat = 0;
    repeat (3) @(negedge clk);
  endtask
  task automatic press(input logic [1:0] col);
    key_valid = 1; key_col = col;
    @(negedge clk);
    key_valid = 0;
    @(negedge clk);
  endtask
  task automatic do_restart;
    restart = 1;
    @(negedge clk);
    restart = 0;
    @(negedge clk);
  endtask
  initial begin
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    expect_lit("reset_outputs", 32'({tile_valid, tile_col, score, hit, miss, game_over}), 32'd0);
    rst_n = 1;
    @(negedge clk);
    beat(0, 0, 0);
    expect_lit("idle_ignores_beat", 32'(tile_valid), 32'd0);
    do_restart;
    beat(0, 0, 0);
    expect_lit("beat1_valid", 32'(tile_valid), 32'h8);
    expect_lit("beat1_col", 32'(tile_col), 32'h40);
    beat(0, 0, 0);
    expect_lit("beat2_valid", 32'(tile_valid), 32'hC);
    expect_lit("beat2_col", 32'(tile_col), 32'h90);
    beat(0, 0, 0);
    expect_lit("beat3_valid", 32'(tile_valid), 32'hE);
    expect_lit("beat3_col", 32'(tile_col), 32'h64);
    beat(0, 0, 0);
    expect_lit("beat4_valid", 32'(tile_valid), 32'hF);
    expect_lit("beat4_col", 32'(tile_col), 32'h99);
    beat(0, 0, 0);
    expect_lit("beat5_over", 32'(game_over), 32'd1);
    expect_lit("beat5_frozen", 32'({tile_valid, tile_col}), 32'hF99);
    do_restart;
    repeat (4) beat(0, 0, 0);
    key_valid = 1; key_col = 2'd1;
    @(negedge clk);
    key_valid = 0;
    expect_lit("hit_pulse", 32'({hit, miss, score}), 32'h801);
    expect_lit("hit_clears_bottom", 32'(tile_valid), 32'hE);
    @(negedge clk);
    beat(0, 0, 0);
    expect_lit("shift_after_hit", 32'({game_over, tile_valid}), 32'h0F);
    beat(1, 0, 2'd2);
    expect_lit("key_with_tick", 32'({game_over, tile_valid, score}), 32'h03C02);
    stop = 1;
    repeat (3) beat(0, 0, 0);
    press(2'd0);
    press(2'd3);
    expect_lit("stop_frozen", 32'({game_over, tile_valid, tile_col, score}), 32'(
               {1'b0, 4'hF, tile_col, 10'd2}));
    expect_lit("stop_col_model", 32'(tile_col), 32'({m_c[3], m_c[2], m_c[1], m_c[0]}));
    stop = 0;
    beat(1, 0, m_c[0]);
    expect_lit("after_stop_shift", 32'({game_over, score}), 32'd3);
    press(2'(m_c[0] + 2'd1));
    expect_lit("wrong_key", 32'({game_over, score}), 32'h403);
    do_restart;
    press(2'd0);
    expect_lit("empty_key_miss", 32'(game_over), 32'd1);
    do_restart;
    repeat (2) beat(0, 0, 0);
    beat(0, 1, 0);
    expect_lit("restart_with_tick", 32'({game_over, tile_valid, score}), 32'd0);
    do_restart;
    repeat (4) beat(0, 0, 0);
    for (int i = 0; i < SMAX + 2; i++) begin
      press(m_c[0]);
      beat(0, 0, 0);
    end
    key_valid = 1; key_col = m_c[0];
    @(negedge clk);
    key_valid = 0;
    expect_lit("saturate_hit", 32'({hit, score}), 32'({1'b1, 10'(SMAX)}));
    @(negedge clk);
    do_restart;
    for (int i = 0; i < 700; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (m_state != 1) do_restart;
      else if (r < 1) beat(0, 1, 0);
      else if (r < 3) press(2'(m_v[0] ? m_c[0] + 2'd1 : $urandom_range(0, 3)));
      else if (r < 5) beat(0, 0, 0);
      else if (r < 15) begin
        stop = 1;
        beat($urandom_range(0, 1) == 1, 0, 2'($urandom_range(0, 3)));
        press(2'($urandom_range(0, 3)));
        stop = 0;
      end else if (r < 50) beat(m_v[0], 0, m_c[0]);
      else begin
        if (m_v[0]) press(m_c[0]);
        beat(0, 0, 0);
      end
    end
    repeat (3) beat(0, 0, 0);
    @(negedge clk);
    #2 rst_n = 0;
    #1 expect_lit("async_reset", 32'({tile_valid, tile_col, score, hit, miss, game_over}), 32'd0);
    @(negedge clk);
    rst_n = 1;
    beat(1, 0, 0);
    expect_lit("idle_after_reset", 32'({game_over, tile_valid, score}), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
